// File: rtl/ila_fifo_readout_if.sv
// Handshake bundle between the ILA FIFO readout engine and its environment:
// control/status, FIFO read port and byte stream to the host link.
interface ila_fifo_readout_if #(
   parameter int unsigned DATA_WIDTH = 20,
   parameter int unsigned CNT_WIDTH  = 16
) ();
   logic                  START;
   logic [CNT_WIDTH-1:0]  WORD_COUNT;
   logic                  ABORT;
   logic                  FIFO_EN;
   logic [DATA_WIDTH-1:0] FIFO_DO;
   logic                  FIFO_EMPTY;
   logic [7:0]            TX_DATA;
   logic                  TX_VALID;
   logic                  TX_READY;
   logic                  TX_LAST;
   logic                  BUSY;
   logic                  DONE;
   logic [CNT_WIDTH-1:0]  WORDS_READ;

   modport master (
      input  START, WORD_COUNT, ABORT, FIFO_DO, FIFO_EMPTY, TX_READY,
      output FIFO_EN, TX_DATA, TX_VALID, TX_LAST, BUSY, DONE, WORDS_READ
   );

   modport slave (
      output START, WORD_COUNT, ABORT, FIFO_DO, FIFO_EMPTY, TX_READY,
      input  FIFO_EN, TX_DATA, TX_VALID, TX_LAST, BUSY, DONE, WORDS_READ
   );
endinterface

// File: rtl/ila_fifo_readout.sv
// ILA sample FIFO readout: pops a requested number of samples and serializes
// each one into bytes on a valid/ready stream toward the host link.
module ila_fifo_readout #(
   parameter int unsigned DATA_WIDTH = 20,
   parameter int unsigned MSB_FIRST  = 1,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input logic                A_CLK,
   input logic                F_RST_N,
   ila_fifo_readout_if.master bus
);
   localparam int unsigned NBYTES = (DATA_WIDTH + 7) / 8;
   localparam int unsigned SW     = NBYTES * 8;
   localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   typedef enum logic [2:0] {StIdle, StPop, StCapture, StSend, StFinish} state_e;

   state_e               state_q;
   logic [SW-1:0]        shift_q;
   logic [IDX_W-1:0]     idx_q;
   logic [CNT_WIDTH-1:0] remaining_q;
   logic [CNT_WIDTH-1:0] words_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 valid_q;
   logic                 last_q;

   logic last_byte;
   logic last_word;
   logic pop;

   assign last_byte = (idx_q == LAST_IDX);
   assign last_word = (remaining_q == CNT_WIDTH'(1));
   assign pop       = (state_q == StPop) && !bus.FIFO_EMPTY;

   assign bus.FIFO_EN    = pop;
   // The current byte always sits at the outgoing end of the shift register.
   assign bus.TX_DATA    = (MSB_FIRST != 0) ? shift_q[SW-1 -: 8] : shift_q[7:0];
   assign bus.TX_VALID   = valid_q;
   assign bus.TX_LAST    = last_q;
   assign bus.BUSY       = busy_q;
   assign bus.DONE       = done_q;
   assign bus.WORDS_READ = words_q;

   always_ff @(posedge A_CLK) begin
      if (!F_RST_N) begin
         state_q     <= StIdle;
         shift_q     <= '0;
         idx_q       <= '0;
         remaining_q <= '0;
         words_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
      end else if (bus.ABORT && (state_q != StIdle)) begin
         // Any popped-but-unsent word is dropped; WORDS_READ keeps its value.
         state_q <= StIdle;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.START) begin
                  remaining_q <= bus.WORD_COUNT;
                  words_q     <= '0;
                  if (bus.WORD_COUNT == '0) begin
                     state_q <= StFinish;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= StPop;
                     busy_q  <= 1'b1;
                  end
               end
            end
            StPop: begin
               if (pop) state_q <= StCapture;
            end
            StCapture: begin
               shift_q <= SW'(bus.FIFO_DO);
               idx_q   <= '0;
               valid_q <= 1'b1;
               last_q  <= (NBYTES == 1) && last_word;
               state_q <= StSend;
            end
            StSend: begin
               if (bus.TX_READY) begin
                  if (last_byte) begin
                     remaining_q <= remaining_q - CNT_WIDTH'(1);
                     words_q     <= words_q + CNT_WIDTH'(1);
                     valid_q     <= 1'b0;
                     last_q      <= 1'b0;
                     if (last_word) begin
                        state_q <= StFinish;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                     end else begin
                        state_q <= StPop;
                     end
                  end else begin
                     idx_q   <= idx_q + IDX_W'(1);
                     shift_q <= (MSB_FIRST != 0) ? (shift_q << 8) : (shift_q >> 8);
                     last_q  <= last_word && ((idx_q + IDX_W'(1)) == LAST_IDX);
                  end
               end
            end
            StFinish: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end
endmodule
